nios_system_nios2_qsys_div_cell: RTL and testbench

NIOS_SYSTEM_NIOS2_QSYS_DIV_CELL -- requirements
Module: nios_system_nios2_qsys_div_cell

---
 rtl/nios_system_nios2_qsys_div_cell_if.sv | 22 ++
 rtl/nios_system_nios2_qsys_div_cell.sv | 116 +++++++++++
 tb/tb_nios_system_nios2_qsys_div_cell.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nios_system_nios2_qsys_div_cell_if.sv
// rtl/nios_system_nios2_qsys_div_cell_if.sv - divider request/result bundle
interface nios_system_nios2_qsys_div_cell_if;
  logic        A_div_start;
  logic        A_div_signed;
  logic [31:0] A_div_src1;
  logic [31:0] A_div_src2;
  logic        A_div_busy;
  logic        A_div_done;
  logic [31:0] A_div_quotient;
  logic [31:0] A_div_remainder;
  logic        A_div_by_zero;

  modport master (
    output A_div_start, A_div_signed, A_div_src1, A_div_src2,
    input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
  );

  modport slave (
    input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
    output A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
  );
endinterface

// File: rtl/nios_system_nios2_qsys_div_cell.sv
// rtl/nios_system_nios2_qsys_div_cell.sv - 32-bit fixed-latency restoring divider
// Signed operands are divided as magnitudes; signs are reapplied in FIX.
module nios_system_nios2_qsys_div_cell (
  input  logic                               clk,
  input  logic                               reset_n,
  nios_system_nios2_qsys_div_cell_if.slave   div
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prem_q, prem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        zero_q, zero_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        by_zero_q, by_zero_d;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic        src1_neg, src2_neg;

  // dvd_q holds the dividend bits not yet consumed and collects quotient bits at its LSB
  assign shifted  = {prem_q, dvd_q[31]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign src1_neg = div.A_div_signed & div.A_div_src1[31];
  assign src2_neg = div.A_div_signed & div.A_div_src2[31];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    zero_d    = zero_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    by_zero_d = by_zero_q;
    case (state_q)
      IDLE: begin
        if (div.A_div_start) begin
          state_d  = CALC;
          sign_a_d = src1_neg;
          sign_b_d = src2_neg;
          dvd_d    = src1_neg ? 32'd0 - div.A_div_src1 : div.A_div_src1;
          dvs_d    = src2_neg ? 32'd0 - div.A_div_src2 : div.A_div_src2;
          zero_d   = (div.A_div_src2 == 32'd0);
          cnt_d    = 5'd31;
          prem_d   = 32'd0;
        end
      end
      CALC: begin
        if (!trial[32]) begin
          prem_d = trial[31:0];
          dvd_d  = {dvd_q[30:0], 1'b1};
        end else begin
          prem_d = shifted[31:0];
          dvd_d  = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = CALC == CALC ? FIX : FIX;
      end
      FIX: begin
        state_d   = DONE;
        by_zero_d = zero_q;
        // Magnitude of a zero-divisor dividend is re-signed to recover the raw src1
        rem_d     = sign_a_q ? 32'd0 - prem_q : prem_q;
        if (zero_q) quot_d = 32'hFFFF_FFFF;
        else        quot_d = (sign_a_q ^ sign_b_q) ? 32'd0 - dvd_q : dvd_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      prem_q    <= 32'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      zero_q    <= 1'b0;
      quot_q    <= 32'd0;
      rem_q     <= 32'd0;
      by_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      zero_q    <= zero_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      by_zero_q <= by_zero_d;
    end
  end

  assign div.A_div_busy      = (state_q != IDLE);
  assign div.A_div_done      = (state_q == DONE);
  assign div.A_div_quotient  = quot_q;
  assign div.A_div_remainder = rem_q;
  assign div.A_div_by_zero   = by_zero_q;

endmodule

// File: tb/tb_nios_system_nios2_qsys_div_cell.sv
// tb/tb_nios_system_nios2_qsys_div_cell.sv - directed and random checks of the divider
module tb_nios_system_nios2_qsys_div_cell;
  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  nios_system_nios2_qsys_div_cell_if dif ();

  nios_system_nios2_qsys_div_cell dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (sg) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q = 32'(la / lb); r = 32'(la % lb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Issues one divide; optionally pulses a stray start with other operands at CALC cycle 5
  task automatic run_op(input string tag, input bit sg, input logic [31:0] a,
                        input logic [31:0] b, input bit ghost);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    model(sg, a, b, eq, er, ez);
    @(negedge clk);
    dif.A_div_start = 1'b1; dif.A_div_signed = sg;
    dif.A_div_src1 = a; dif.A_div_src2 = b;
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (lat == 0) begin
        dif.A_div_start = 1'b0;
        dif.A_div_signed = ~sg;
        dif.A_div_src1 = $urandom; dif.A_div_src2 = $urandom;
        chk({tag, "_busy"}, {31'd0, dif.A_div_busy}, 32'd1);
      end
      if (ghost && lat == 5) begin
        dif.A_div_start = 1'b1; dif.A_div_src1 = 32'd77; dif.A_div_src2 = 32'd5;
      end
      if (ghost && lat == 6) dif.A_div_start = 1'b0;
      if (dif.A_div_done) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_q"}, dif.A_div_quotient, eq);
    chk({tag, "_r"}, dif.A_div_remainder, er);
    chk({tag, "_z"}, {31'd0, dif.A_div_by_zero}, {31'd0, ez});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, dif.A_div_done}, 32'd0);
    chk({tag, "_hold"}, dif.A_div_quotient, eq);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        ez, sg;
    int          n;
    reset_n = 1'b0;
    dif.A_div_start = 1'b0; dif.A_div_signed = 1'b0;
    dif.A_div_src1 = 32'd0; dif.A_div_src2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, dif.A_div_busy}, 32'd0);
    chk("rst_done", {31'd0, dif.A_div_done}, 32'd0);
    chk("rst_q", dif.A_div_quotient, 32'd0);
    chk("rst_r", dif.A_div_remainder, 32'd0);
    chk("rst_z", {31'd0, dif.A_div_by_zero}, 32'd0);
    reset_n = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("u_dz", 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    run_op("s_dz", 1'b1, 32'h1234_5678, 32'd0, 1'b0);
    run_op("s_dz_neg", 1'b1, 32'h8765_4321, 32'd0, 1'b0);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("u_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i % 4 == 0) ? ($urandom & 32'hFF) : $urandom >> $urandom_range(0, 31);
      run_op("rand", 1'($urandom & 1), a, b, 1'b0);
    end
    run_op("ghost", 1'b0, 32'd1000, 32'd3, 1'b1);

    // Abort in the middle of CALC
    @(negedge clk);
    dif.A_div_start = 1'b1; dif.A_div_signed = 1'b0;
    dif.A_div_src1 = 32'd999; dif.A_div_src2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    dif.A_div_start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, dif.A_div_busy}, 32'd0);
    chk("abort_q", dif.A_div_quotient, 32'd0);
    chk("abort_r", dif.A_div_remainder, 32'd0);
    chk("abort_z", {31'd0, dif.A_div_by_zero}, 32'd0);
    reset_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.A_div_done) n++;
    end
    chk("abort_nodone", n, 0);

    // Reset wins over start on the same edge
    @(negedge clk);
    dif.A_div_start = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", {31'd0, dif.A_div_busy}, 32'd0);
    dif.A_div_start = 1'b0; reset_n = 1'b1;

    // Start held high: back-to-back operations
    @(negedge clk);
    sg = 1'b1; a = $urandom; b = $urandom >> 8;
    dif.A_div_start = 1'b1; dif.A_div_signed = sg;
    dif.A_div_src1 = a; dif.A_div_src2 = b;
    for (int op = 0; op < 3; op++) begin
      model(sg, a, b, eq, er, ez);
      n = 0;
      @(negedge clk);
      while (!dif.A_div_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_done_seen", {31'd0, dif.A_div_done}, 32'd1);
      chk("b2b_q", dif.A_div_quotient, eq);
      chk("b2b_r", dif.A_div_remainder, er);
      sg = ~sg; a = $urandom; b = $urandom >> 4;
      dif.A_div_signed = sg; dif.A_div_src1 = a; dif.A_div_src2 = b;
      @(negedge clk);
      chk("b2b_idle_done", {31'd0, dif.A_div_done}, 32'd0);
      chk("b2b_idle_busy", {31'd0, dif.A_div_busy}, 32'd0);
      if (op == 2) dif.A_div_start = 1'b0;
      else begin
        @(negedge clk);
        chk("b2b_accept", {31'd0, dif.A_div_busy}, 32'd1);
      end
    end
    dif.A_div_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
